// File: rtl/visited_store_mp_if.sv
// visited_store_mp_if: control, mark-visited, query and status bundle of the visited store
interface visited_store_mp_if #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 5,
  parameter int NUM_PORTS   = 2
);
  logic                             start;
  logic [INDEX_WIDTH-1:0]           number_of_nodes;
  logic [NUM_PORTS-1:0]             set_en;
  logic [INDEX_WIDTH*NUM_PORTS-1:0] set_index;
  logic [INDEX_WIDTH*NUM_PORTS-1:0] set_prev;
  logic [INDEX_WIDTH-1:0]           query_index;
  logic                             query_visited;
  logic [INDEX_WIDTH-1:0]           query_prev;
  logic [INDEX_WIDTH-1:0]           unvisited_nodes;
  logic                             all_visited;
  logic                             busy;
  logic                             error;
  logic [INDEX_WIDTH*MAX_NODES-1:0] prev_vector_flattened;
  modport master (
    output start, number_of_nodes, set_en, set_index, set_prev, query_index,
    input  query_visited, query_prev, unvisited_nodes, all_visited, busy, error,
           prev_vector_flattened
  );
  modport slave (
    input  start, number_of_nodes, set_en, set_index, set_prev, query_index,
    output query_visited, query_prev, unvisited_nodes, all_visited, busy, error,
           prev_vector_flattened
  );
endinterface

// File: rtl/visited_store_mp.sv
// visited_store_mp: multi-port visited flags and predecessor store with timed clear sweep
module visited_store_mp #(
  parameter int MAX_NODES   = 16,
  parameter int INDEX_WIDTH = 5,
  parameter int NUM_PORTS   = 2
) (
  input logic               clock,
  input logic               reset,
  visited_store_mp_if.slave bus
);
  localparam logic [INDEX_WIDTH-1:0] SENTINEL = '1;
  localparam logic [INDEX_WIDTH-1:0] LAST     = INDEX_WIDTH'(MAX_NODES - 1);
  localparam logic [INDEX_WIDTH-1:0] CAP      = INDEX_WIDTH'(MAX_NODES);
  typedef enum logic [1:0] {IDLE, INIT, ACTIVE} state_t;
  typedef logic [INDEX_WIDTH-1:0] prev_arr_t [MAX_NODES];
  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] n, ptr, unvisited, acc_count, q_prev;
  logic [MAX_NODES-1:0]   visited;
  prev_arr_t              prev_mem;
  logic [INDEX_WIDTH-1:0] idx [NUM_PORTS];
  logic [INDEX_WIDTH-1:0] pv [NUM_PORTS];
  logic [NUM_PORTS-1:0]   acc;
  logic                   err, q_vis, busy, all_visited, sweep_done, set_err;
  // Out-of-range indices read as visited, so they are never accepted and query as visited
  function automatic logic vis_of(input logic [MAX_NODES-1:0] v, input logic [INDEX_WIDTH-1:0] i);
    vis_of = 1'b1;
    for (int j = 0; j < MAX_NODES; j++)
      if (i == INDEX_WIDTH'(j)) vis_of = v[j];
  endfunction
  function automatic logic [INDEX_WIDTH-1:0] prev_of(input prev_arr_t m, input logic [INDEX_WIDTH-1:0] i);
    prev_of = SENTINEL;
    for (int j = 0; j < MAX_NODES; j++)
      if (i == INDEX_WIDTH'(j)) prev_of = m[j];
  endfunction
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
    assign idx[p] = bus.set_index[INDEX_WIDTH*p +: INDEX_WIDTH];
    assign pv[p]  = bus.set_prev[INDEX_WIDTH*p +: INDEX_WIDTH];
  end
  for (genvar j = 0; j < MAX_NODES; j++) begin : g_flat
    assign bus.prev_vector_flattened[INDEX_WIDTH*j +: INDEX_WIDTH] = prev_mem[j];
  end
  // Per-port acceptance: in range, unvisited, and no lower port aiming at the same node
  always_comb begin
    acc       = '0;
    acc_count = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      acc[p] = state == ACTIVE && idx[p] < n && !vis_of(visited, idx[p]);
      for (int q = 0; q < p; q++)
        if (bus.set_en[q] && idx[q] == idx[p]) acc[p] = 1'b0;
      acc[p]    = acc[p] && bus.set_en[p];
      acc_count = acc_count + INDEX_WIDTH'(acc[p]);
    end
  end
  assign set_err    = |(bus.set_en & ~acc);
  assign sweep_done = state == INIT && ptr == LAST;
  // State register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_next;
  // Next state: start always restarts the sweep; the sweep ends after the last entry
  always_comb state_next = bus.start ? INIT : sweep_done ? ACTIVE : state;
  // State-decoded outputs
  always_comb begin
    busy        = state == INIT;
    all_visited = state == ACTIVE && unvisited == '0;
  end
  // Control registers: latched node count, sweep pointer, remaining count, sticky error
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      n         <= '0;
      ptr       <= '0;
      unvisited <= '0;
      err       <= 1'b0;
    end else if (bus.start) begin
      n   <= bus.number_of_nodes > CAP ? CAP : bus.number_of_nodes;
      ptr <= '0;
      err <= bus.number_of_nodes > CAP;
    end else begin
      ptr       <= busy ? ptr + 1'b1 : ptr;
      unvisited <= sweep_done ? n : unvisited - acc_count;
      err       <= err | set_err;
    end
  // Storage: one sweep entry per cycle in INIT, accepted mark-visited writes in ACTIVE
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      visited <= '1;
      for (int j = 0; j < MAX_NODES; j++) prev_mem[j] <= '0;
    end else if (!bus.start) begin
      for (int j = 0; j < MAX_NODES; j++) begin
        if (busy && ptr == INDEX_WIDTH'(j)) begin
          visited[j]  <= INDEX_WIDTH'(j) >= n;
          prev_mem[j] <= SENTINEL;
        end
        for (int p = 0; p < NUM_PORTS; p++)
          if (acc[p] && idx[p] == INDEX_WIDTH'(j)) begin
            visited[j]  <= 1'b1;
            prev_mem[j] <= pv[p];
          end
      end
    end
  // Registered lookup; sees the contents present before this edge's writes
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      q_vis  <= 1'b0;
      q_prev <= '0;
    end else begin
      q_vis  <= vis_of(visited, bus.query_index);
      q_prev <= prev_of(prev_mem, bus.query_index);
    end
  assign bus.query_visited   = q_vis;
  assign bus.query_prev      = q_prev;
  assign bus.unvisited_nodes = unvisited;
  assign bus.all_visited     = all_visited;
  assign bus.busy            = busy;
  assign bus.error           = err;
endmodule

// File: tb/tb_visited_store_mp.sv
// tb_visited_store_mp: directed self-checking bench for the multi-port visited store
module tb_visited_store_mp;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int compared = 0;
  int mismatched = 0;
  visited_store_mp_if #(.MAX_NODES(8), .INDEX_WIDTH(4), .NUM_PORTS(2)) bus ();
  visited_store_mp #(.MAX_NODES(8), .INDEX_WIDTH(4), .NUM_PORTS(2)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic sets(input logic [1:0] en, input logic [3:0] i0, input logic [3:0] p0,
                      input logic [3:0] i1, input logic [3:0] p1);
    bus.set_en    = en;
    bus.set_index = {i1, i0};
    bus.set_prev  = {p1, p0};
  endtask
  function automatic logic [3:0] prev_at(input int j);
    logic [31:0] v;
    v = bus.prev_vector_flattened;
    return v[4*j +: 4];
  endfunction
  initial begin
    bus.start = 1'b0;
    bus.number_of_nodes = '0;
    bus.query_index = '0;
    sets(2'b00, 0, 0, 0, 0);
    tick();
    tick();
    check("rst_busy", bus.busy, 0);
    check("rst_unvisited", bus.unvisited_nodes, 0);
    check("rst_all_visited", bus.all_visited, 0);
    check("rst_error", bus.error, 0);
    check("rst_qvis", bus.query_visited, 0);
    check("rst_qprev", bus.query_prev, 0);
    check("rst_prevvec", bus.prev_vector_flattened, 32'h0);
    reset = 1'b0;
    tick();
    check("idle_q0_vis", bus.query_visited, 1);
    check("idle_q0_prev", bus.query_prev, 0);
    bus.query_index = 4'd9;
    tick();
    check("oor_q_vis", bus.query_visited, 1);
    check("oor_q_prev", bus.query_prev, 4'hF);
    sets(2'b01, 0, 0, 0, 0);
    tick();
    sets(2'b00, 0, 0, 0, 0);
    check("idle_set_error", bus.error, 1);
    check("idle_set_busy", bus.busy, 0);
    // new graph with N=5
    bus.start = 1'b1;
    bus.number_of_nodes = 4'd5;
    tick();
    bus.start = 1'b0;
    bus.query_index = 4'd6;
    check("start5_busy", bus.busy, 1);
    check("start5_error_clr", bus.error, 0);
    for (int i = 1; i < 8; i++) begin
      tick();
      check("sweep5_busy", bus.busy, 1);
    end
    tick();
    check("sweep5_done_busy", bus.busy, 0);
    check("sweep5_unvisited", bus.unvisited_nodes, 5);
    check("sweep5_prevvec", bus.prev_vector_flattened, 32'hFFFF_FFFF);
    check("sweep5_error", bus.error, 0);
    check("q6_vis", bus.query_visited, 1);
    check("q6_prev", bus.query_prev, 4'hF);
    check("sweep5_all_visited", bus.all_visited, 0);
    // two ports, distinct nodes; query reads pre-write contents
    sets(2'b11, 4'd2, 4'd0, 4'd4, 4'd2);
    bus.query_index = 4'd4;
    tick();
    sets(2'b00, 0, 0, 0, 0);
    check("dual_unvisited", bus.unvisited_nodes, 3);
    check("dual_prev2", prev_at(2), 4'd0);
    check("dual_prev4", prev_at(4), 4'd2);
    check("dual_error", bus.error, 0);
    check("q4_before_vis", bus.query_visited, 0);
    check("q4_before_prev", bus.query_prev, 4'hF);
    tick();
    check("q4_after_vis", bus.query_visited, 1);
    check("q4_after_prev", bus.query_prev, 4'd2);
    // same node from both ports: port 0 wins
    sets(2'b11, 4'd3, 4'd1, 4'd3, 4'd7);
    tick();
    sets(2'b00, 0, 0, 0, 0);
    check("dup_prev3", prev_at(3), 4'd1);
    check("dup_unvisited", bus.unvisited_nodes, 2);
    check("dup_error", bus.error, 1);
    sets(2'b01, 4'd3, 4'd5, 0, 0);
    tick();
    sets(2'b00, 0, 0, 0, 0);
    check("reset3_prev3", prev_at(3), 4'd1);
    check("reset3_unvisited", bus.unvisited_nodes, 2);
    check("reset3_error", bus.error, 1);
    // restart with N=3
    bus.start = 1'b1;
    bus.number_of_nodes = 4'd3;
    tick();
    bus.start = 1'b0;
    check("start3_error_clr", bus.error, 0);
    check("start3_busy", bus.busy, 1);
    for (int i = 1; i < 8; i++) tick();
    tick();
    check("sweep3_busy", bus.busy, 0);
    check("sweep3_unvisited", bus.unvisited_nodes, 3);
    check("sweep3_error", bus.error, 0);
    sets(2'b01, 4'd6, 4'd0, 0, 0);
    tick();
    sets(2'b00, 0, 0, 0, 0);
    check("oor_set_error", bus.error, 1);
    check("oor_set_unvisited", bus.unvisited_nodes, 3);
    check("oor_set_prev6", prev_at(6), 4'hF);
    // mark every node
    sets(2'b11, 4'd0, 4'd7, 4'd1, 4'd0);
    tick();
    check("mark01_unvisited", bus.unvisited_nodes, 1);
    check("mark01_all_visited", bus.all_visited, 0);
    sets(2'b01, 4'd2, 4'd1, 0, 0);
    bus.query_index = 4'd7;
    tick();
    check("mark2_unvisited", bus.unvisited_nodes, 0);
    check("mark2_all_visited", bus.all_visited, 1);
    check("mark2_prev0", prev_at(0), 4'd7);
    // start wins over same-cycle sets
    bus.start = 1'b1;
    sets(2'b11, 4'd0, 4'd2, 4'd1, 4'd2);
    tick();
    bus.start = 1'b0;
    sets(2'b00, 0, 0, 0, 0);
    check("startset_busy", bus.busy, 1);
    check("startset_error", bus.error, 0);
    check("startset_all_visited", bus.all_visited, 0);
    check("startset_prev0", prev_at(0), 4'd7);
    for (int i = 1; i <= 4; i++) tick();
    check("midinit_prev0", prev_at(0), 4'hF);
    check("midinit_qprev", bus.query_prev, 4'hF);
    // asynchronous reset mid-sweep
    reset = 1'b1;
    #1;
    check("areset_busy", bus.busy, 0);
    check("areset_error", bus.error, 0);
    check("areset_unvisited", bus.unvisited_nodes, 0);
    check("areset_all_visited", bus.all_visited, 0);
    check("areset_qvis", bus.query_visited, 0);
    check("areset_qprev", bus.query_prev, 0);
    check("areset_prevvec", bus.prev_vector_flattened, 32'h0);
    reset = 1'b0;
    tick();
    check("post_reset_q7_vis", bus.query_visited, 1);
    check("post_reset_q7_prev", bus.query_prev, 0);
    check("post_reset_busy", bus.busy, 0);
    // N=0 graph with a set during the sweep
    bus.start = 1'b1;
    bus.number_of_nodes = 4'd0;
    tick();
    bus.start = 1'b0;
    check("start0_busy", bus.busy, 1);
    sets(2'b01, 4'd0, 4'd0, 0, 0);
    tick();
    sets(2'b00, 0, 0, 0, 0);
    check("init_set_error", bus.error, 1);
    for (int i = 2; i < 8; i++) tick();
    check("sweep0_still_busy", bus.busy, 1);
    tick();
    check("sweep0_busy", bus.busy, 0);
    check("sweep0_all_visited", bus.all_visited, 1);
    check("sweep0_unvisited", bus.unvisited_nodes, 0);
    // oversized N clamps to capacity and flags an error
    bus.start = 1'b1;
    bus.number_of_nodes = 4'd10;
    tick();
    bus.start = 1'b0;
    check("big_error", bus.error, 1);
    check("big_busy", bus.busy, 1);
    for (int i = 1; i < 8; i++) tick();
    tick();
    check("big_unvisited", bus.unvisited_nodes, 8);
    check("big_busy_done", bus.busy, 0);
    check("big_all_visited", bus.all_visited, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/visited_store_mp.md
Name: visited_store_mp

Overview:
- Multi-port successor to the single-port visited store in the Dijkstra datapath.
- Tracks visited flags and predecessor ("prev") indices for up to MAX_NODES nodes.
- Accepts NUM_PORTS mark-visited writes per cycle, runs a timed clear sweep when a new graph starts, and provides a registered query port, an unvisited count and a completion flag for the controller FSM.
- The flattened prev vector feeds path reconstruction.

Parameters:
- MAX_NODES, 16, node capacity. Must satisfy MAX_NODES <= 2^INDEX_WIDTH - 1.
- INDEX_WIDTH, 5, width of node indices and counts.
- NUM_PORTS, 2, number of independent mark-visited write channels.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle pulse that begins a new graph: latches number_of_nodes and starts the clear sweep.
- number_of_nodes  in  INDEX_WIDTH  node count N, sampled only when start=1.
- set_en  in  NUM_PORTS  per-port mark-visited request.
- set_index  in  INDEX_WIDTH*NUM_PORTS  flattened node index per port; port p occupies bits [INDEX_WIDTH*(p+1)-1 : INDEX_WIDTH*p].
- set_prev  in  INDEX_WIDTH*NUM_PORTS  flattened predecessor per port, same packing as set_index.
- query_index  in  INDEX_WIDTH  node to look up.
- query_visited  out  1  registered visited flag of query_index.
- query_prev  out  INDEX_WIDTH  registered prev entry of query_index.
- unvisited_nodes  out  INDEX_WIDTH  count of unvisited nodes with index < N.
- all_visited  out  1  high when state=ACTIVE and unvisited_nodes=0.
- busy  out  1  high while in INIT.
- error  out  1  sticky flag for an illegal set.
- prev_vector_flattened  out  INDEX_WIDTH*MAX_NODES  prev entry j at bits [INDEX_WIDTH*(j+1)-1 : INDEX_WIDTH*j].

Behaviour:
- SENTINEL = all-ones INDEX_WIDTH value; it means "no predecessor".
- Reset (asynchronous, any state):
  - state=IDLE, N=0.
  - All visited bits=1; all prev entries=0.
  - unvisited_nodes=0, all_visited=0, busy=0, error=0, query_visited=0, query_prev=0.
- States: IDLE, INIT, ACTIVE.
- IDLE:
  - start -> INIT; latch N; sweep pointer ptr=0; error cleared.
  - Any set_en -> error=1; no state change.
- INIT (busy=1):
  - One entry per cycle: visited[ptr] = (ptr >= N); prev[ptr] = SENTINEL; ptr increments.
  - After ptr=MAX_NODES-1 is written -> ACTIVE, unvisited_nodes=N. The sweep takes exactly MAX_NODES cycles.
  - N > MAX_NODES: treat as MAX_NODES and set error=1.
  - N=0: sweep still runs; on entering ACTIVE, all_visited=1.
  - set_en during INIT: ignored, error=1.
- ACTIVE: per port p with set_en[p]=1:
  - Accepted only if all of these hold: set_index[p] < N; the node is not visited; no lower-numbered port targets the same index this cycle.
  - Accepted write: visited=1, prev=set_prev[p].
  - Every rejected set raises error. Same-cycle duplicates: the lowest-numbered port wins.
  - unvisited_nodes decrements by the number of accepted writes in that cycle (0..NUM_PORTS). It never underflows, by construction.
- start in INIT or ACTIVE: restarts the sweep at ptr=0 with the new N and clears error.
- start takes priority over set_en in the same cycle: those sets are dropped silently, with no error.
- Query (1-cycle latency, read-before-write):
  - Outputs at edge k+1 reflect the state before any write at that same edge.
  - query_index >= MAX_NODES returns visited=1, prev=SENTINEL.
  - Queries work in every state.
- prev_vector_flattened: direct register view with no latency; updates on the same edge as the write.
- all_visited is a registered-state combinational decode; it drops to 0 the cycle after start.

Test Plan (MAX_NODES=8, INDEX_WIDTH=4, NUM_PORTS=2, SENTINEL=4'hF):
1. Reset, then start with N=5 -> busy=1 for 8 cycles. Then busy=0, unvisited_nodes=5, all prev=4'hF, query_index=6 returns visited=1, error=0.
2. ACTIVE: port0 (2,prev 0) and port1 (4,prev 2) in the same cycle -> unvisited_nodes 5->3; prev[2]=0, prev[4]=2 visible on the same edge; query_index=4 one cycle later returns visited=1, prev=2.
3. Both ports set index 3 in one cycle (prev 1 and prev 7) -> prev[3]=1, unvisited decrements by 1, error=1 next cycle. Then re-set index 3 -> no change, error stays 1.
4. Set index 6 (>= N) and set during INIT -> no state change, error=1. Then start with N=3 -> error=0, sweep reruns, unvisited_nodes=3.
5. Mark all 3 nodes -> all_visited=1. Assert start with set_en on the same cycle -> sets dropped, no error, busy=1.
6. Assert reset mid-INIT (ptr=4) -> all outputs return to reset values immediately, state=IDLE. Then start with N=0 -> after 8 cycles all_visited=1, unvisited_nodes=0.
